// File: rtl/usart_loopback_if.sv
// Serial pins plus control/status bundle for usart_loopback.
// Driver side (board/bench) uses master; the echo block uses slave.
interface usart_loopback_if #(
  parameter int DIVIDER_WIDTH = 12,
  parameter int FIFO_DEPTH    = 16
);
  logic [DIVIDER_WIDTH-1:0]      clock_divider;
  logic                          tx_enable;
  logic                          clear_status;
  logic                          rx_pin;
  logic                          tx_pin;
  logic [$clog2(FIFO_DEPTH):0]   fifo_level;
  logic                          overflow;
  logic                          rx_error;

  modport master (
    output clock_divider, tx_enable, clear_status, rx_pin,
    input  tx_pin, fifo_level, overflow, rx_error
  );

  modport slave (
    input  clock_divider, tx_enable, clear_status, rx_pin,
    output tx_pin, fifo_level, overflow, rx_error
  );
endinterface

// File: rtl/usart_loopback.sv
// USART echo: 16x-oversampled RX -> circular FIFO -> TX, single clock domain.
// Define USART_LOOPBACK_PARITY_EN to add one even-parity bit in both directions.
module usart_loopback #(
  parameter int DATA_BITS     = 8,
  parameter int FIFO_DEPTH    = 16,
  parameter int DIVIDER_WIDTH = 12
) (
  input  logic             comm_clock,
  input  logic             reset,
  usart_loopback_if.slave  uart
);
  localparam int CW = DIVIDER_WIDTH - 4;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [3:0]    LAST_BIT   = 4'(DATA_BITS - 1);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

  // Oversampling tick; the period is reloaded only at wrap
  logic [CW-1:0] div_cnt, div_limit, div_field;
  logic          tick;
  logic          unused_div_lsbs;

  assign div_field       = uart.clock_divider[DIVIDER_WIDTH-1:4];
  assign unused_div_lsbs = ^uart.clock_divider[3:0];
  assign tick            = (div_cnt == div_limit);

  always_ff @(posedge comm_clock or posedge reset) begin
    if (reset) begin
      div_cnt   <= '0;
      div_limit <= '0;
    end else if (tick) begin
      div_cnt   <= '0;
      div_limit <= (div_field == '0) ? '0 : div_field - CW'(1);
    end else begin
      div_cnt <= div_cnt + CW'(1);
    end
  end

  logic rx_meta, rx_sync, rx_prev;

  always_ff @(posedge comm_clock or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart.rx_pin;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA,
`ifdef USART_LOOPBACK_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP, RX_WAIT_HIGH
  } rx_state_t;

  rx_state_t              rx_state;
  logic [3:0]             rx_sub, rx_bit;
  logic [DATA_BITS-1:0]   rx_shift;
  logic                   rx_push, rx_err_q, rx_mid;
`ifdef USART_LOOPBACK_PARITY_EN
  logic                   rx_par_bad;
`endif

  assign rx_mid = tick && (rx_sub == 4'd15);

  always_ff @(posedge comm_clock or posedge reset) begin
    if (reset) begin
      rx_state <= RX_IDLE;
      rx_sub   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_push  <= 1'b0;
      rx_err_q <= 1'b0;
`ifdef USART_LOOPBACK_PARITY_EN
      rx_par_bad <= 1'b0;
`endif
    end else begin
      rx_push  <= 1'b0;
      rx_err_q <= 1'b0;
      if (tick) rx_sub <= rx_sub + 4'd1;
      case (rx_state)
        RX_IDLE:
          if (rx_prev && !rx_sync) begin
            rx_state <= RX_START;
            rx_sub   <= '0;
          end
        RX_START:
          if (tick && rx_sub == 4'd7) begin
            if (rx_sync) rx_state <= RX_IDLE;
            else begin
              rx_state <= RX_DATA;
              rx_sub   <= '0;
              rx_bit   <= '0;
            end
          end
        RX_DATA:
          if (rx_mid) begin
            rx_shift <= {rx_sync, rx_shift[DATA_BITS-1:1]};
            rx_bit   <= rx_bit + 4'd1;
`ifdef USART_LOOPBACK_PARITY_EN
            if (rx_bit == LAST_BIT) rx_state <= RX_PARITY;
`else
            if (rx_bit == LAST_BIT) rx_state <= RX_STOP;
`endif
          end
`ifdef USART_LOOPBACK_PARITY_EN
        RX_PARITY:
          if (rx_mid) begin
            rx_par_bad <= rx_sync ^ (^rx_shift);
            rx_state   <= RX_STOP;
          end
`endif
        RX_STOP:
          if (rx_mid) begin
            if (!rx_sync) begin
              rx_err_q <= 1'b1;
              rx_state <= RX_WAIT_HIGH;
            end else begin
              rx_state <= RX_IDLE;
`ifdef USART_LOOPBACK_PARITY_EN
              if (rx_par_bad) rx_err_q <= 1'b1;
              else            rx_push  <= 1'b1;
`else
              rx_push <= 1'b1;
`endif
            end
          end
        RX_WAIT_HIGH:
          if (tick && rx_sync) rx_state <= RX_IDLE;
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // A push into a full FIFO still lands if a pop frees a slot that cycle
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [LW-1:0]        level;
  logic                 full, do_push, tx_pop, ovf_q;

  assign full    = (level == FULL_LEVEL);
  assign do_push = rx_push && (!full || tx_pop);

  always_ff @(posedge comm_clock) begin
    if (do_push) mem[wr_ptr] <= rx_shift;
  end

  always_ff @(posedge comm_clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (tx_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, tx_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (rx_push && !do_push)   ovf_q <= 1'b1;
      else if (uart.clear_status) ovf_q <= 1'b0;
    end
  end

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA,
`ifdef USART_LOOPBACK_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_t;

  tx_state_t            tx_state;
  logic [3:0]           tx_sub, tx_bit;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_q, tx_end;
`ifdef USART_LOOPBACK_PARITY_EN
  logic                 tx_par;
`endif

  assign tx_pop = (tx_state == TX_IDLE) && tick && uart.tx_enable && (level != '0);
  assign tx_end = tick && (tx_sub == 4'd15);

  always_ff @(posedge comm_clock or posedge reset) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_sub   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_q     <= 1'b1;
`ifdef USART_LOOPBACK_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else begin
      if (tick) tx_sub <= tx_sub + 4'd1;
      case (tx_state)
        TX_IDLE:
          if (tx_pop) begin
            tx_shift <= mem[rd_ptr];
`ifdef USART_LOOPBACK_PARITY_EN
            tx_par   <= ^mem[rd_ptr];
`endif
            tx_q     <= 1'b0;
            tx_sub   <= '0;
            tx_state <= TX_START;
          end
        TX_START:
          if (tx_end) begin
            tx_q     <= tx_shift[0];
            tx_bit   <= '0;
            tx_state <= TX_DATA;
          end
        TX_DATA:
          if (tx_end) begin
            if (tx_bit == LAST_BIT) begin
`ifdef USART_LOOPBACK_PARITY_EN
              tx_q     <= tx_par;
              tx_state <= TX_PARITY;
`else
              tx_q     <= 1'b1;
              tx_state <= TX_STOP;
`endif
            end else begin
              tx_q     <= tx_shift[1];
              tx_shift <= tx_shift >> 1;
              tx_bit   <= tx_bit + 4'd1;
            end
          end
`ifdef USART_LOOPBACK_PARITY_EN
        TX_PARITY:
          if (tx_end) begin
            tx_q     <= 1'b1;
            tx_state <= TX_STOP;
          end
`endif
        TX_STOP:
          if (tx_end) tx_state <= TX_IDLE;
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  assign uart.tx_pin     = tx_q;
  assign uart.fifo_level = level;
  assign uart.overflow   = ovf_q;
  assign uart.rx_error   = rx_err_q;
endmodule
